// File: rtl/freq_meas_sequencer.sv
// ---------------------------------------------------------------------------
// freq_meas_sequencer
//
// Wishbone master that runs complete measurements on the vernier frequency
// counter. It clears and arms the counter, then polls its control register
// until the counter reports completion. It then reads back the coarse and
// fine counts and presents them to the host. A saturating timeout counter
// forces an abort if the counter never completes. The host can also abort
// a run, and can request continuous back-to-back runs.
//
// Ports
//   clk_i          bus clock, shared with the counter
//   rst_ni         asynchronous active-low reset
//   start_i        start a measurement (only honoured in IDLE)
//   abort_i        cancel the measurement in progress
//   continuous_i   re-arm straight after DONE when high
//   busy_o         high in every state except IDLE
//   valid_o        one-cycle pulse; coarse_o/fine_o carry new results
//   timeout_o      one-cycle pulse in the ABORT cycle of a timeout
//   coarse_o       last coarse count
//   fine_o         last fine count
//   m_*            Wishbone master; single-cycle strobes, ack not used
// ---------------------------------------------------------------------------
module freq_meas_sequencer #(
    parameter int POLL_INTERVAL  = 16,
    parameter int TIMEOUT_CYCLES = 100_000_000,
    parameter int READ_LATENCY   = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        continuous_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic        timeout_o,
    output logic [31:0] coarse_o,
    output logic [31:0] fine_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic        m_cyc_o,
    output logic        m_stb_o
);

    // Shared down-counter covers both the poll gap and the read latency.
    localparam int               CNT_W     = $clog2(POLL_INTERVAL) + 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(POLL_INTERVAL - 1);
    localparam logic [CNT_W-1:0] LAT_LOAD  = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [32:0]      TMO_LIM   = 33'(TIMEOUT_CYCLES);

    localparam logic [31:0] ADDR_CTRL   = 32'h0000_0008;
    localparam logic [31:0] ADDR_COARSE = 32'h0000_0009;
    localparam logic [31:0] ADDR_FINE   = 32'h0000_000a;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_ARM,
        S_WAIT,
        S_POLL,
        S_POLL_CAP,
        S_RDC,
        S_RDC_CAP,
        S_RDF,
        S_RDF_CAP,
        S_DONE,
        S_ABORT
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_next_is_tmo;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_tmo;
    logic              r_tmo_flag;
    logic              r_abort_pend;
    logic [31:0]       r_coarse_hold;
    logic [31:0]       r_fine_hold;
    logic [31:0]       r_coarse;
    logic [31:0]       r_fine;

    logic              w_abort;
    logic              w_cnt_zero;
    logic              w_tmo_now;
    logic              w_poll_done;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // An abort pulse seen during a read is remembered until the capture ends.
    assign w_abort     = abort_i | r_abort_pend;
    assign w_cnt_zero  = (r_cnt == '0);
    // True when the current counted cycle is the TIMEOUT_CYCLES-th one.
    assign w_tmo_now   = (({1'b0, r_tmo} + 33'd1) >= TMO_LIM);
    assign w_poll_done = !m_dat_i[7] && m_dat_i[0];

    // ---- state register and datapath registers ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_tmo         <= '0;
            r_tmo_flag    <= 1'b0;
            r_abort_pend  <= 1'b0;
            r_coarse_hold <= '0;
            r_fine_hold   <= '0;
            r_coarse      <= '0;
            r_fine        <= '0;
        end else begin
            r_state    <= w_next;
            r_tmo_flag <= w_next_is_tmo;

            if (w_next == S_WAIT && r_state != S_WAIT) begin
                r_cnt <= WAIT_LOAD;
            end else if ((w_next == S_POLL_CAP || w_next == S_RDC_CAP ||
                          w_next == S_RDF_CAP) && w_next != r_state) begin
                r_cnt <= LAT_LOAD;
            end else if (!w_cnt_zero) begin
                r_cnt <= r_cnt - CNT_ONE;
            end

            if (r_state == S_ARM) begin
                r_tmo <= '0;
            end else if (r_state == S_WAIT || r_state == S_POLL ||
                         r_state == S_POLL_CAP) begin
                r_tmo <= sat_inc(r_tmo);
            end

            if (r_state == S_IDLE || r_state == S_ABORT) begin
                r_abort_pend <= 1'b0;
            end else if (abort_i) begin
                r_abort_pend <= 1'b1;
            end

            if (r_state == S_RDC_CAP && w_cnt_zero) begin
                r_coarse_hold <= m_dat_i;
            end
            if (r_state == S_RDF_CAP && w_cnt_zero) begin
                r_fine_hold <= m_dat_i;
            end
            if (r_state == S_DONE) begin
                r_coarse <= r_coarse_hold;
                r_fine   <= r_fine_hold;
            end
        end
    end

    // ---- next state and bus outputs ----
    always_comb begin
        w_next        = r_state;
        w_next_is_tmo = 1'b0;
        m_addr_o      = '0;
        m_dat_o       = '0;
        m_we_o        = 1'b0;
        m_sel_o       = 4'h0;
        m_cyc_o       = 1'b0;
        m_stb_o       = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start_i && !abort_i) w_next = S_CLR;
            end
            S_CLR: begin
                m_addr_o = ADDR_CTRL;
                m_dat_o  = 32'h0000_0001;
                m_we_o   = 1'b1;
                w_next   = w_abort ? S_ABORT : S_ARM;
            end
            S_ARM: begin
                m_addr_o = ADDR_CTRL;
                m_dat_o  = 32'h0000_0080;
                m_we_o   = 1'b1;
                w_next   = w_abort ? S_ABORT : S_WAIT;
            end
            S_WAIT: begin
                if (w_abort) begin
                    w_next = S_ABORT;
                end else if (w_tmo_now) begin
                    w_next        = S_ABORT;
                    w_next_is_tmo = 1'b1;
                end else if (w_cnt_zero) begin
                    w_next = S_POLL;
                end
            end
            S_POLL: begin
                m_addr_o = ADDR_CTRL;
                w_next   = S_POLL_CAP;
            end
            S_POLL_CAP: begin
                // A done result in the same capture beats a timeout.
                if (w_cnt_zero) begin
                    if (w_abort) begin
                        w_next = S_ABORT;
                    end else if (w_poll_done) begin
                        w_next = S_RDC;
                    end else if (w_tmo_now) begin
                        w_next        = S_ABORT;
                        w_next_is_tmo = 1'b1;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_RDC: begin
                m_addr_o = ADDR_COARSE;
                w_next   = S_RDC_CAP;
            end
            S_RDC_CAP: begin
                if (w_cnt_zero) w_next = w_abort ? S_ABORT : S_RDF;
            end
            S_RDF: begin
                m_addr_o = ADDR_FINE;
                w_next   = S_RDF_CAP;
            end
            S_RDF_CAP: begin
                if (w_cnt_zero) w_next = w_abort ? S_ABORT : S_DONE;
            end
            S_DONE: begin
                if (w_abort)           w_next = S_ABORT;
                else if (continuous_i) w_next = S_CLR;
                else                   w_next = S_IDLE;
            end
            S_ABORT: begin
                m_addr_o = ADDR_CTRL;
                m_we_o   = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase

        // Every issued access is a single strobe with all byte lanes.
        if (r_state == S_CLR || r_state == S_ARM || r_state == S_POLL ||
            r_state == S_RDC || r_state == S_RDF || r_state == S_ABORT) begin
            m_cyc_o = 1'b1;
            m_stb_o = 1'b1;
            m_sel_o = 4'hF;
        end
    end

    assign busy_o    = (r_state != S_IDLE);
    assign valid_o   = (r_state == S_DONE);
    assign timeout_o = (r_state == S_ABORT) && r_tmo_flag;

    // In DONE the result registers are still loading; present the holding
    // registers so valid_o and the new values appear together.
    assign coarse_o  = (r_state == S_DONE) ? r_coarse_hold : r_coarse;
    assign fine_o    = (r_state == S_DONE) ? r_fine_hold   : r_fine;

endmodule

// File: tb/tb_freq_meas_sequencer.sv
`timescale 1ns/1ps
module tb_freq_meas_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    int          checks   = 0;
    int          failures = 0;

    // Main instance: long timeout, driven by a behavioural counter model.
    logic        start, abort, cont;
    logic        busy, valid, tmo;
    logic [31:0] coarse, fine, addr, dato, dati;
    logic        we, cyc, stb;
    logic [3:0]  sel;

    // Second instance: short timeout, counter never reports done.
    logic        start_t, abort_t, cont_t;
    logic        busy_t, valid_t, tmo_t;
    logic [31:0] coarse_t, fine_t, addr_t, dato_t, dati_t;
    logic        we_t, cyc_t, stb_t;
    logic [3:0]  sel_t;

    freq_meas_sequencer #(.POLL_INTERVAL(16), .TIMEOUT_CYCLES(100000), .READ_LATENCY(1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .continuous_i(cont),
        .busy_o(busy), .valid_o(valid), .timeout_o(tmo), .coarse_o(coarse), .fine_o(fine),
        .m_addr_o(addr), .m_dat_o(dato), .m_dat_i(dati), .m_we_o(we), .m_sel_o(sel),
        .m_cyc_o(cyc), .m_stb_o(stb));

    freq_meas_sequencer #(.POLL_INTERVAL(16), .TIMEOUT_CYCLES(200), .READ_LATENCY(1)) u_dut_to (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_t), .abort_i(abort_t), .continuous_i(cont_t),
        .busy_o(busy_t), .valid_o(valid_t), .timeout_o(tmo_t), .coarse_o(coarse_t), .fine_o(fine_t),
        .m_addr_o(addr_t), .m_dat_o(dato_t), .m_dat_i(dati_t), .m_we_o(we_t), .m_sel_o(sel_t),
        .m_cyc_o(cyc_t), .m_stb_o(stb_t));

    // Bus event decodes for the main instance.
    wire acc    = cyc & stb & (sel == 4'hF);
    wire w_clr  = acc &  we & (addr == 32'h8) & (dato == 32'h01);
    wire w_arm  = acc &  we & (addr == 32'h8) & (dato == 32'h80);
    wire w_abw  = acc &  we & (addr == 32'h8) & (dato == 32'h00);
    wire w_poll = acc & !we & (addr == 32'h8);
    wire w_rdc  = acc & !we & (addr == 32'h9);
    wire w_rdf  = acc & !we & (addr == 32'ha);
    wire w_junk = !cyc & (stb | we | (sel != 4'h0) | (addr != 32'h0) | (dato != 32'h0));
    wire w_abw_t = cyc_t & stb_t & we_t & (sel_t == 4'hF) & (addr_t == 32'h8) & (dato_t == 32'h0);

    // Counter model: one-cycle read latency, done a programmable time after arm.
    logic [31:0] mdl_coarse, mdl_fine;
    int          mdl_delay;
    logic        mdl_en, mdl_done;
    int          mdl_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_en   <= 1'b0;
            mdl_done <= 1'b0;
            mdl_cnt  <= 0;
            dati     <= 32'h0;
        end else begin
            if (mdl_en) begin
                if (mdl_cnt == 0) begin
                    mdl_en   <= 1'b0;
                    mdl_done <= 1'b1;
                end else begin
                    mdl_cnt <= mdl_cnt - 1;
                end
            end
            if (cyc && stb) begin
                if (we) begin
                    if (addr == 32'h8) begin
                        if (dato[0]) begin
                            mdl_en   <= 1'b0;
                            mdl_done <= 1'b0;
                        end else if (dato[7]) begin
                            mdl_en   <= 1'b1;
                            mdl_done <= 1'b0;
                            mdl_cnt  <= mdl_delay;
                        end else begin
                            mdl_en <= 1'b0;
                        end
                    end
                end else begin
                    case (addr)
                        32'h8:   dati <= {24'h0, mdl_en, 6'h0, mdl_done};
                        32'h9:   dati <= mdl_coarse;
                        32'ha:   dati <= mdl_fine;
                        default: dati <= 32'hDEAD_BEEF;
                    endcase
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        start = 0; abort = 0; cont = 0;
        start_t = 0; abort_t = 0; cont_t = 0;
        dati_t = 32'h0000_0080;
        mdl_coarse = 0; mdl_fine = 0; mdl_delay = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, valid, tmo, cyc, stb, we} !== 6'b0 || sel !== 4'h0 || addr !== 32'h0 || dato !== 32'h0) begin
            failures++;
            $display("FAIL reset_ctrl_bus busy=%b valid=%b tmo=%b cyc=%b stb=%b we=%b sel=%h addr=%h dat=%h exp all 0",
                     busy, valid, tmo, cyc, stb, we, sel, addr, dato);
        end
        checks++;
        if (coarse !== 32'h0 || fine !== 32'h0) begin
            failures++;
            $display("FAIL reset_results coarse=%0d fine=%0d exp 0/0", coarse, fine);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int clr_c = -1, arm_c = -1, poll_c = -1, rdc_c = -1, rdf_c = -1, val_c = -1;
        int nval = 0, junk = 0;
        logic [31:0] vc = 0, vf = 0;
        mdl_coarse = 1000; mdl_fine = 1001; mdl_delay = 500;
        start = 1;
        for (int k = 1; k <= 560; k++) begin
            @(negedge clk);
            if (k == 1) start = 0;
            if (w_clr && clr_c < 0)   clr_c = k;
            if (w_arm && arm_c < 0)   arm_c = k;
            if (w_poll && poll_c < 0) poll_c = k;
            if (w_rdc && rdc_c < 0)   rdc_c = k;
            if (w_rdf && rdf_c < 0)   rdf_c = k;
            if (w_junk) junk++;
            if (valid) begin
                nval++; val_c = k; vc = coarse; vf = fine;
            end
        end
        checks++; if (clr_c !== 1)   begin failures++; $display("FAIL single_clr_cycle got=%0d exp=1", clr_c); end
        checks++; if (arm_c !== 2)   begin failures++; $display("FAIL single_arm_cycle got=%0d exp=2", arm_c); end
        checks++; if (poll_c !== 19) begin failures++; $display("FAIL single_first_poll got=%0d exp=19", poll_c); end
        checks++; if (rdc_c !== 507) begin failures++; $display("FAIL single_rdc_cycle got=%0d exp=507", rdc_c); end
        checks++; if (rdf_c !== 509) begin failures++; $display("FAIL single_rdf_cycle got=%0d exp=509", rdf_c); end
        checks++; if (val_c !== 511) begin failures++; $display("FAIL single_valid_cycle got=%0d exp=511", val_c); end
        checks++; if (nval !== 1)    begin failures++; $display("FAIL single_valid_count got=%0d exp=1", nval); end
        checks++; if (vc !== 32'd1000 || vf !== 32'd1001) begin
            failures++; $display("FAIL single_values got=%0d/%0d exp=1000/1001", vc, vf);
        end
        checks++; if (junk !== 0)    begin failures++; $display("FAIL single_bus_idle got=%0d exp=0", junk); end
        checks++; if (busy !== 1'b0 || coarse !== 32'd1000 || fine !== 32'd1001) begin
            failures++; $display("FAIL single_after busy=%b res=%0d/%0d exp 0 1000/1001", busy, coarse, fine);
        end
    endtask

    task automatic test_timeout();
        int ntmo = 0, tmo_c = -1, nval = 0, nabw = 0, busy_after = -1;
        logic bus_ok = 1'b0;
        start_t = 1;
        for (int k = 1; k <= 260; k++) begin
            @(negedge clk);
            if (k == 1) start_t = 0;
            if (valid_t) nval++;
            if (w_abw_t) nabw++;
            if (tmo_t) begin
                ntmo++; tmo_c = k; bus_ok = w_abw_t;
            end
            if (tmo_c > 0 && k == tmo_c + 1) busy_after = int'(busy_t);
        end
        checks++; if (ntmo !== 1)      begin failures++; $display("FAIL timeout_pulses got=%0d exp=1", ntmo); end
        checks++; if (tmo_c !== 203)   begin failures++; $display("FAIL timeout_cycle got=%0d exp=203", tmo_c); end
        checks++; if (bus_ok !== 1'b1) begin failures++; $display("FAIL timeout_with_write got=%b exp=1", bus_ok); end
        checks++; if (nabw !== 1)      begin failures++; $display("FAIL timeout_abort_writes got=%0d exp=1", nabw); end
        checks++; if (nval !== 0)      begin failures++; $display("FAIL timeout_no_valid got=%0d exp=0", nval); end
        checks++; if (busy_after !== 0 || busy_t !== 1'b0) begin
            failures++; $display("FAIL timeout_busy_after got=%0d exp=0", busy_after);
        end
    endtask

    task automatic test_abort();
        int abw_c = -1, ntmo = 0, nval = 0, busy12 = -1;
        mdl_coarse = 2000; mdl_fine = 2001; mdl_delay = 50;
        start = 1;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            if (k == 1)  start = 0;
            if (k == 11) abort = 0;
            if (w_abw && abw_c < 0) abw_c = k;
            if (tmo) ntmo++;
            if (valid) nval++;
            if (k == 12) busy12 = int'(busy);
            if (k == 10) abort = 1;
        end
        checks++; if (abw_c !== 11) begin failures++; $display("FAIL abort_write_cycle got=%0d exp=11", abw_c); end
        checks++; if (ntmo !== 0)   begin failures++; $display("FAIL abort_no_timeout got=%0d exp=0", ntmo); end
        checks++; if (nval !== 0)   begin failures++; $display("FAIL abort_no_valid got=%0d exp=0", nval); end
        checks++; if (busy12 !== 0) begin failures++; $display("FAIL abort_busy_drop got=%0d exp=0", busy12); end
        checks++; if (coarse !== 32'd1000 || fine !== 32'd1001) begin
            failures++; $display("FAIL abort_results_kept got=%0d/%0d exp=1000/1001", coarse, fine);
        end
    endtask

    task automatic test_continuous();
        logic [31:0] exp_c [3] = '{32'd10, 32'd20, 32'd30};
        logic [31:0] exp_f [3] = '{32'd11, 32'd21, 32'd31};
        int n = 0, clr_at = -1, stopped = 0;
        mdl_coarse = exp_c[0]; mdl_fine = exp_f[0]; mdl_delay = 30;
        cont = 1; start = 1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 1) start = 0;
            if (abort) abort = 0;
            if (k == clr_at) begin
                checks++;
                if (w_clr !== 1'b1) begin
                    failures++; $display("FAIL cont_clr_after_valid n=%0d got=%b exp=1", n, w_clr);
                end
                if (n == 3) begin
                    cont = 0; abort = 1; stopped = 1;
                end
            end
            if (valid) begin
                checks++;
                if (n > 2 || coarse !== exp_c[n % 3] || fine !== exp_f[n % 3]) begin
                    failures++; $display("FAIL cont_values n=%0d got=%0d/%0d", n, coarse, fine);
                end
                n++;
                clr_at = k + 1;
                if (n < 3) begin
                    mdl_coarse = exp_c[n]; mdl_fine = exp_f[n];
                end
            end
            if (stopped == 1 && !busy && !abort) break;
        end
        checks++; if (n !== 3)      begin failures++; $display("FAIL cont_valid_count got=%0d exp=3", n); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cont_stop_busy got=%b exp=0", busy); end
        abort = 0; cont = 0;
    endtask

    task automatic test_collisions();
        int acts = 0, nval = 0, rdc_seen = 0, post = 0, fell = 0;
        logic [31:0] vc = 0, vf = 0;
        start = 1; abort = 1;
        @(negedge clk);
        start = 0; abort = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy || cyc) acts++;
            @(negedge clk);
        end
        checks++; if (acts !== 0) begin failures++; $display("FAIL coll_start_abort_idle got=%0d exp=0", acts); end

        mdl_coarse = 77; mdl_fine = 78; mdl_delay = 40;
        start = 1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (start) start = 0;
            if (valid) begin
                nval++; vc = coarse; vf = fine;
            end
            if (fell && (busy || cyc)) post++;
            if (nval > 0 && !busy) fell = 1;
            if (w_rdc && rdc_seen == 0) begin
                rdc_seen = 1; start = 1;
            end
        end
        checks++; if (rdc_seen !== 1) begin failures++; $display("FAIL coll_rdc_seen got=%0d exp=1", rdc_seen); end
        checks++; if (nval !== 1)     begin failures++; $display("FAIL coll_valid_count got=%0d exp=1", nval); end
        checks++; if (vc !== 32'd77 || vf !== 32'd78) begin
            failures++; $display("FAIL coll_values got=%0d/%0d exp=77/78", vc, vf);
        end
        checks++; if (post !== 0)     begin failures++; $display("FAIL coll_restart_after got=%0d exp=0", post); end
    endtask

    task automatic test_reset_mid_poll();
        int found = 0, acts = 0;
        mdl_delay = 500;
        start = 1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) start = 0;
            if (w_poll) begin
                found = 1; break;
            end
        end
        checks++; if (found !== 1) begin failures++; $display("FAIL rst_poll_reached got=%0d exp=1", found); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, valid, tmo, cyc, stb, we} !== 6'b0 || sel !== 4'h0 || addr !== 32'h0 ||
            dato !== 32'h0 || coarse !== 32'h0 || fine !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid_poll busy=%b cyc=%b stb=%b we=%b sel=%h addr=%h res=%0d/%0d exp all 0",
                     busy, cyc, stb, we, sel, addr, coarse, fine);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (busy || cyc) acts++;
        end
        checks++; if (acts !== 0) begin failures++; $display("FAIL rst_stays_idle got=%0d exp=0", acts); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_timeout();
        test_abort();
        test_continuous();
        test_collisions();
        test_reset_mid_poll();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/freq_meas_sequencer.md
# freq_meas_sequencer

Wishbone master that runs complete measurements on the vernier frequency counter without CPU involvement. It clears and arms the counter, polls its control register for completion, reads back the coarse and fine counts, and presents them on a simple host-side result interface. It enforces a timeout and supports abort and continuous back-to-back operation. It sits between the control unit and the counter's Wishbone slave port.

## Interface
- `POLL_INTERVAL`, 16: idle cycles between completion polls (min 2)
- `TIMEOUT_CYCLES`, 100_000_000: cycles from arm to forced abort (min 1)
- `READ_LATENCY`, 1: cycles from read strobe to valid `m_dat_i` (1..3)
- `clk_i` in 1: bus clock, same clock as the counter's `clk_i`
- `rst_ni` in 1: asynchronous, active-low reset
- `start_i` in 1: starts a measurement when sampled high in IDLE
- `abort_i` in 1: cancels the measurement in progress
- `continuous_i` in 1: when high at DONE, re-arm immediately
- `busy_o` out 1: high in every state except IDLE
- `valid_o` out 1: one-cycle pulse; results updated
- `timeout_o` out 1: one-cycle pulse on timeout abort
- `coarse_o` out 32: last coarse count
- `fine_o` out 32: last fine count
- `m_addr_o` out 32, `m_dat_o` out 32, `m_dat_i` in 32, `m_we_o` out 1, `m_sel_o` out 4, `m_cyc_o` out 1, `m_stb_o` out 1: Wishbone master

## Operation
- Counter register map: 0x8 control (bit7 enable, bit0 counter clear), 0x9 coarse, 0xa fine.
- Done condition: a control read with bit7 = 0 and bit0 = 1.
- Every access is one cycle with `m_cyc_o`, `m_stb_o` and `m_sel_o` = 4'hF asserted. `ack` is not used.
- Read data is sampled `READ_LATENCY` cycles after the strobe cycle.
- Bus outputs are 0 whenever no access is issued. This guarantees idle gaps so the counter's FSM advances.
- States:
  - IDLE: if `start_i` && !`abort_i`, go to CLR.
  - CLR: write 0x01 to 0x8; go to ARM.
  - ARM: write 0x80 to 0x8; clear the timeout counter; go to WAIT.
  - WAIT: count `POLL_INTERVAL` cycles, then go to POLL.
  - POLL: read 0x8, then capture. Done goes to RDC; otherwise go to WAIT.
  - RDC: read 0x9 and capture into a coarse holding register; go to RDF.
  - RDF: read 0xa and capture into a fine holding register; go to DONE.
  - DONE: load `coarse_o`/`fine_o`, pulse `valid_o`. If `continuous_i`, go to CLR; else go to IDLE.
  - ABORT: write 0x00 to 0x8; go to IDLE.
- Timeout counter: 32-bit, saturating. It increments in WAIT and POLL. Reaching `TIMEOUT_CYCLES` goes to ABORT with a `timeout_o` pulse in the ABORT cycle.
  - If the timeout occurs during a POLL capture, the capture completes first. A done result in that same capture wins over the timeout.
- `abort_i`: in any non-IDLE state other than ABORT it goes to ABORT after any in-flight read capture finishes. There is no `timeout_o` pulse and no `valid_o`, and results are unchanged.
  - Abort also wins over `start_i` in IDLE.
  - Abort in DONE: the `valid_o` pulse still fires, then the block goes to ABORT instead of CLR.
- `start_i` while busy is ignored.
- `coarse_o`/`fine_o` hold their values until the next DONE.

## Timing
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Timeout counter and holding registers are 0.
- Reset is asynchronous mid-operation. The block returns to IDLE at once, the bus is released, and no further writes occur.
- Reference cycle sequence, with `start_i` sampled at edge 0:
  - CLR strobe in cycle 1.
  - ARM strobe in cycle 2.
  - First POLL strobe in cycle 3+`POLL_INTERVAL`, captured `READ_LATENCY` later.
- Poll cadence: POLL strobe, then the capture wait, then `POLL_INTERVAL` idle cycles.
- After a done capture in cycle P, with `READ_LATENCY`=1:
  - RDC strobe at P+1, capture at P+2.
  - RDF strobe at P+3, capture at P+4.
  - `valid_o` with new results at P+5.
- Continuous mode: CLR strobe at P+6.
- Timeout: ABORT write strobe and `timeout_o` occur in the same cycle. `busy_o` drops the next cycle.
- `busy_o` rises the cycle after `start_i` is sampled. It falls in the cycle following DONE or ABORT.

## Test plan
- Reset:
  - Stimulus: assert `rst_ni`=0 mid-POLL.
  - Required: all outputs 0 within the same cycle. After release with no `start_i`, `busy_o` stays 0 for 50 cycles.
- Single measurement:
  - Stimulus: counter model reports done after 500 cycles with coarse=1000, fine=1001.
  - Required: bus shows write 0x01@0x8, then write 0x80@0x8, polls, read 0x9, read 0xa. One `valid_o` pulse with `coarse_o`=1000 and `fine_o`=1001 at P+5.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=200, counter never reports done.
  - Required: `timeout_o` pulses once, coinciding with write 0x00@0x8. No `valid_o`. `busy_o`=0 afterwards.
- Abort:
  - Stimulus: `abort_i` pulsed during WAIT after one prior good measurement (1000/1001).
  - Required: write 0x00@0x8 follows. No `timeout_o`. Results remain 1000/1001.
- Continuous:
  - Stimulus: `continuous_i`=1, model returns 10/11, then 20/21, then 30/31.
  - Required: three `valid_o` pulses with matching values. CLR strobe exactly 1 cycle after each `valid_o`.
- Collisions:
  - Stimulus: `start_i` and `abort_i` high together in IDLE; then `start_i` re-asserted during RDC.
  - Required: in the first case the block stays IDLE with no bus access. In the second case the re-assert is ignored and exactly one `valid_o` pulse occurs.
